// File: rtl/xpb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xpb_pkg
// Summary  : Shared sizing helpers and default parameters for the XPB LUT
//            accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package xpb_pkg;

    localparam int XPB_DEF_WIDTH    = 1024;
    localparam int XPB_DEF_IDX_BITS = 5;
    localparam int XPB_DEF_NUM_LUTS = 4;

    function automatic int xpb_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int xpb_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Table-select width; never zero so a single-table build still has a port.
    function automatic int xpb_sel_w(input int num_luts);
        return xpb_max(1, xpb_clog2(num_luts));
    endfunction

    // Sum width large enough that adding num_luts full-scale entries cannot wrap.
    function automatic int xpb_sum_w(input int width, input int num_luts);
        return width + xpb_sel_w(num_luts);
    endfunction

endpackage
`default_nettype wire

// File: rtl/xpb_lut_bank.sv
`default_nettype none
// ============================================================================
// Module   : xpb_lut_bank
// Summary  : One 2^IDX_BITS x WIDTH table with a write port and a registered
//            read port; entry 0 always reads as zero.
// Revision : 1.0 - initial release
// ============================================================================
module xpb_lut_bank
    import xpb_pkg::*;
#(
    parameter int WIDTH    = XPB_DEF_WIDTH,
    parameter int IDX_BITS = XPB_DEF_IDX_BITS
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [IDX_BITS-1:0] i_waddr,
    input  logic [WIDTH-1:0]    i_wdata,
    input  logic                i_re,
    input  logic [IDX_BITS-1:0] i_raddr,
    output logic [WIDTH-1:0]    o_rdata
);

    localparam int c_depth = 1 << IDX_BITS;

    logic [WIDTH-1:0] mem_q [c_depth];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    // Table contents are deliberately not reset; readiness is tracked upstream.
    always_ff @(posedge clk) begin
        if (i_we && (i_waddr != '0)) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (i_re) begin
            rdata_d = (i_raddr == '0) ? '0 : mem_q[i_raddr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/xpb_lut_accum.sv
`default_nettype none
// ============================================================================
// Module   : xpb_lut_accum
// Summary  : Two-stage lookup/accumulate over NUM_LUTS XPB tables: stage 1
//            reads one entry per table, stage 2 sums them without reduction.
// Revision : 1.0 - initial release
// ============================================================================
module xpb_lut_accum
    import xpb_pkg::*;
#(
    parameter int  WIDTH    = XPB_DEF_WIDTH,
    parameter int  IDX_BITS = XPB_DEF_IDX_BITS,
    parameter int  NUM_LUTS = XPB_DEF_NUM_LUTS,
    localparam int SEL_W    = xpb_sel_w(NUM_LUTS),
    localparam int SUM_W    = xpb_sum_w(WIDTH, NUM_LUTS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ld_valid,
    input  logic [SEL_W-1:0]             ld_lut,
    input  logic [IDX_BITS-1:0]          ld_idx,
    input  logic [WIDTH-1:0]             ld_data,
    input  logic                         ld_last,
    input  logic                         tbl_clr,
    output logic                         tbl_ready,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_LUTS*IDX_BITS-1:0] in_idx,
    output logic                         out_valid,
    output logic [SUM_W-1:0]             out_sum
);

    localparam int c_tree_lvls   = xpb_clog2(NUM_LUTS);
    localparam int c_tree_leaves = 1 << c_tree_lvls;

    logic             tbl_ready_d, tbl_ready_q;
    logic             s1_valid_d,  s1_valid_q;
    logic             out_valid_d, out_valid_q;
    logic [SUM_W-1:0] out_sum_d,   out_sum_q;

    logic             w_accept;
    logic [WIDTH-1:0] w_rdata [NUM_LUTS];
    logic [SUM_W-1:0] w_tree  [c_tree_leaves];
    logic [SUM_W-1:0] w_sum;

    // Writes block acceptance, so a bank never sees a read and write together.
    assign in_ready = tbl_ready_q && !ld_valid;
    assign w_accept = in_valid && in_ready;

    generate
        for (genvar k = 0; k < NUM_LUTS; k++) begin : g_bank
            logic w_we;
            assign w_we = ld_valid && (ld_lut == SEL_W'(k));

            xpb_lut_bank #(
                .WIDTH    (WIDTH),
                .IDX_BITS (IDX_BITS)
            ) u_bank (
                .clk     (clk),
                .i_we    (w_we),
                .i_waddr (ld_idx),
                .i_wdata (ld_data),
                .i_re    (w_accept),
                .i_raddr (in_idx[k*IDX_BITS +: IDX_BITS]),
                .o_rdata (w_rdata[k])
            );
        end
    endgenerate

    // Pairwise reduction in place: each level halves the live leaf count.
    always_comb begin
        for (int k = 0; k < c_tree_leaves; k++) begin
            w_tree[k] = '0;
        end
        for (int k = 0; k < NUM_LUTS; k++) begin
            w_tree[k] = {{(SUM_W-WIDTH){1'b0}}, w_rdata[k]};
        end
        for (int l = 0; l < c_tree_lvls; l++) begin
            for (int j = 0; j < (c_tree_leaves >> (l + 1)); j++) begin
                w_tree[j] = w_tree[2*j] + w_tree[2*j+1];
            end
        end
        w_sum = w_tree[0];
    end

    always_comb begin
        tbl_ready_d = tbl_ready_q;
        if (tbl_clr) begin
            tbl_ready_d = 1'b0;
        end else if (ld_valid && ld_last) begin
            tbl_ready_d = 1'b1;
        end
        s1_valid_d  = w_accept;
        out_valid_d = s1_valid_q;
        out_sum_d   = s1_valid_q ? w_sum : out_sum_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_ready_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else begin
            tbl_ready_q <= tbl_ready_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
        end
    end

    assign tbl_ready = tbl_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

endmodule
`default_nettype wire
